// File: rtl/seg7_pkg.sv
// seg7_pkg: shared seven-segment constants and hex-to-segment encoding (active-low abcdefg).
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [15:0][6:0] HEX_SEG = {
        7'b0111000, 7'b0110000, 7'b1000010, 7'b0110001,
        7'b1100000, 7'b0001000, 7'b0000100, 7'b0000000,
        7'b0001111, 7'b0100000, 7'b0100100, 7'b1001100,
        7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        return HEX_SEG[n];
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: combinational 4-bit hex to active-low seven-segment decoder.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver: multiplexed common-anode display driver with frame shadowing,
// leading-zero suppression, per-digit blanking/dp and PWM brightness.
module seven_seg_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SLOT_W     = 16,
    parameter int BRIGHT_W   = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digit_data,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    lz_suppress,
    input  logic [BRIGHT_W-1:0]     brightness,
    output logic [NUM_DIGITS-1:0]   AN,
    output logic [6:0]              segment_data,
    output logic                    dp,
    output logic                    frame_start
);

    localparam int IDX_W = $clog2(NUM_DIGITS);

    logic [SLOT_W-1:0]       slot_cnt;
    logic [IDX_W-1:0]        digit_idx;
    logic [4*NUM_DIGITS-1:0] data_sh;
    logic [NUM_DIGITS-1:0]   dp_sh;
    logic [NUM_DIGITS-1:0]   en_sh;
    logic                    lz_sh;
    logic [NUM_DIGITS:1]     zero_from;
    logic [NUM_DIGITS-1:0]   lit;
    logic [3:0]              nib;
    logic [6:0]              dec_seg;
    logic                    wrap;
    logic                    load;
    logic                    show;
    logic                    guard;

    assign wrap  = &slot_cnt;
    assign load  = wrap && (digit_idx == IDX_W'(NUM_DIGITS - 1));
    assign guard = slot_cnt == '0;

    // zero_from[i]: suppression enabled and nibbles i..NUM_DIGITS-1 are all zero
    assign zero_from[NUM_DIGITS] = lz_sh;
    for (genvar i = 1; i < NUM_DIGITS; i++) begin : g_lz
        assign zero_from[i] = zero_from[i+1] && (data_sh[4*i +: 4] == 4'd0);
    end

    assign lit  = en_sh & ~{zero_from[NUM_DIGITS-1:1], 1'b0};
    assign nib  = data_sh[{digit_idx, 2'b00} +: 4];
    assign show = lit[digit_idx] && (slot_cnt[SLOT_W-1 -: BRIGHT_W] <= brightness);

    seg7_hex_decode u_dec (
        .nibble(nib),
        .seg   (dec_seg)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            slot_cnt     <= '0;
            digit_idx    <= '0;
            data_sh      <= '0;
            dp_sh        <= '0;
            en_sh        <= '0;
            lz_sh        <= 1'b0;
            AN           <= '1;
            segment_data <= SEG_BLANK;
            dp           <= 1'b1;
            frame_start  <= 1'b0;
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
            if (wrap)
                digit_idx <= load ? '0 : digit_idx + 1'b1;
            if (load) begin
                data_sh <= digit_data;
                dp_sh   <= dp_in;
                en_sh   <= digit_en;
                lz_sh   <= lz_suppress;
            end
            frame_start  <= load;
            AN           <= (show && !guard) ? ~(NUM_DIGITS'(1) << digit_idx) : '1;
            segment_data <= show ? dec_seg : SEG_BLANK;
            dp           <= show ? ~dp_sh[digit_idx] : 1'b1;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb_seven_seg_scan_driver: table-driven frame checks with a per-slot scoreboard, plus
// reset, shadowing and 3-digit scan sequences.
module tb_seven_seg_scan_driver;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] digit_data = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  digit_en = '0;
    logic        lz_suppress = 1'b0;
    logic [3:0]  brightness = '0;
    logic [3:0]  AN;
    logic [6:0]  segment_data;
    logic        dp;
    logic        frame_start;

    logic [11:0] d3_data = 12'h123;
    logic [2:0]  d3_an;
    logic [6:0]  d3_seg;
    logic        d3_dp;
    logic        d3_fs;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    seven_seg_scan_driver #(.NUM_DIGITS(4), .SLOT_W(5), .BRIGHT_W(4)) dut (
        .clock(clock), .reset(reset), .digit_data(digit_data), .dp_in(dp_in),
        .digit_en(digit_en), .lz_suppress(lz_suppress), .brightness(brightness),
        .AN(AN), .segment_data(segment_data), .dp(dp), .frame_start(frame_start)
    );

    seven_seg_scan_driver #(.NUM_DIGITS(3), .SLOT_W(2), .BRIGHT_W(1)) dut3 (
        .clock(clock), .reset(reset), .digit_data(d3_data), .dp_in(3'b000),
        .digit_en(3'b111), .lz_suppress(1'b0), .brightness(1'b1),
        .AN(d3_an), .segment_data(d3_seg), .dp(d3_dp), .frame_start(d3_fs)
    );

    typedef struct {
        logic [15:0] data;
        logic [3:0]  dpi;
        logic [3:0]  en;
        logic        lz;
        logic [3:0]  br;
        logic        cont;
        logic        chg;
        logic [15:0] chg_data;
        logic [27:0] segs;
        logic [3:0]  lit;
        logic [3:0]  dpx;
    } vec_t;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        int         cnt;
    } exp_t;

    exp_t q[$];
    vec_t tv[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic wait_frame();
        int i = 0;
        while (frame_start !== 1'b1 && i < 400) begin
            @(negedge clock);
            i++;
        end
        chk("frame_timeout", {31'd0, frame_start}, 32'd1);
    endtask

    task automatic check_frame(input vec_t v);
        exp_t e;
        logic [3:0] a;
        int n;
        for (int k = 0; k < 4; k++) begin
            a = 4'b1 << k;
            e.an  = v.lit[k] ? ~a : 4'hF;
            e.seg = v.segs[7*k +: 7];
            e.dp  = v.dpx[k];
            e.cnt = v.lit[k] ? 2 * int'(v.br) + 1 : 0;
            q.push_back(e);
        end
        for (int k = 0; k < 4; k++) begin
            e = q.pop_front();
            n = 0;
            for (int c = 0; c < 32; c++) begin
                @(posedge clock);
                @(negedge clock);
                if (k == 0 && c == 0) chk("fs_one_cycle", {31'd0, frame_start}, 32'd0);
                if (c == 0) chk("guard_an", {28'd0, AN}, 32'hF);
                if (c == 1) begin
                    chk("an", {28'd0, AN}, {28'd0, e.an});
                    chk("seg", {25'd0, segment_data}, {25'd0, e.seg});
                    chk("dp", {31'd0, dp}, {31'd0, e.dp});
                end
                if (AN != 4'hF) n++;
                if (k == 0 && c == 31 && v.chg) digit_data = v.chg_data;
            end
            chk("pwm_on_cycles", n, e.cnt);
        end
    endtask

    initial begin
        logic [2:0] a3;
        logic [6:0] s3 [3];
        int i;
        //        data    dpi  en  lz  br  cont chg chg_data  segs {d3,d2,d1,d0}                                  lit    dpx
        tv[0] = '{16'h3A5F, 4'h0, 4'hF, 0, 4'hF, 0, 0, 16'h0, {7'b0000110, 7'b0001000, 7'b0100100, 7'b0111000}, 4'hF, 4'hF};
        tv[1] = '{16'h1234, 4'h0, 4'hF, 0, 4'hF, 0, 1, 16'h5678, {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}, 4'hF, 4'hF};
        tv[2] = '{16'h5678, 4'h0, 4'hF, 0, 4'hF, 1, 0, 16'h0, {7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000}, 4'hF, 4'hF};
        tv[3] = '{16'h0040, 4'h0, 4'hF, 1, 4'hF, 0, 0, 16'h0, {7'b1111111, 7'b1111111, 7'b1001100, 7'b0000001}, 4'b0011, 4'hF};
        tv[4] = '{16'h0000, 4'h0, 4'hF, 1, 4'hF, 0, 0, 16'h0, {7'b1111111, 7'b1111111, 7'b1111111, 7'b0000001}, 4'b0001, 4'hF};
        tv[5] = '{16'h0040, 4'h0, 4'hF, 0, 4'hF, 0, 0, 16'h0, {7'b0000001, 7'b0000001, 7'b1001100, 7'b0000001}, 4'hF, 4'hF};
        tv[6] = '{16'h7C9E, 4'b0011, 4'b1010, 0, 4'hF, 0, 0, 16'h0, {7'b0001111, 7'b1111111, 7'b0000100, 7'b1111111}, 4'b1010, 4'b1101};
        tv[7] = '{16'h8D2B, 4'b0100, 4'hF, 0, 4'd3, 0, 0, 16'h0, {7'b0000000, 7'b1000010, 7'b0010010, 7'b1100000}, 4'hF, 4'b1011};
        tv[8] = '{16'h0F00, 4'hF, 4'hF, 1, 4'd0, 0, 0, 16'h0, {7'b1111111, 7'b0111000, 7'b0000001, 7'b0000001}, 4'b0111, 4'b1000};

        repeat (3) @(negedge clock);
        chk("rst_an", {28'd0, AN}, 32'hF);
        chk("rst_seg", {25'd0, segment_data}, 32'h7F);
        chk("rst_dp", {31'd0, dp}, 32'd1);
        chk("rst_fs", {31'd0, frame_start}, 32'd0);
        reset = 1'b0;

        for (int v = 0; v < 9; v++) begin
            if (!tv[v].cont) begin
                @(negedge clock);
                digit_data  = tv[v].data;
                dp_in       = tv[v].dpi;
                digit_en    = tv[v].en;
                lz_suppress = tv[v].lz;
                brightness  = tv[v].br;
            end
            wait_frame();
            check_frame(tv[v]);
        end

        @(negedge clock);
        digit_data  = 16'h1234;
        dp_in       = 4'h0;
        digit_en    = 4'hF;
        lz_suppress = 1'b0;
        brightness  = 4'hF;
        wait_frame();
        repeat (40) @(negedge clock);
        chk("pre_reset_an", {28'd0, AN}, 32'hD);
        reset = 1'b1;
        repeat (3) begin
            @(negedge clock);
            chk("mid_rst_an", {28'd0, AN}, 32'hF);
            chk("mid_rst_seg", {25'd0, segment_data}, 32'h7F);
            chk("mid_rst_dp", {31'd0, dp}, 32'd1);
            chk("mid_rst_fs", {31'd0, frame_start}, 32'd0);
        end
        reset = 1'b0;
        i = 0;
        while (i < 200) begin
            @(negedge clock);
            i++;
            if (i == 64) chk("shadow_cleared_an", {28'd0, AN}, 32'hF);
            if (frame_start) break;
        end
        chk("first_load_cycle", i, 128);

        s3[0] = 7'b0000110;
        s3[1] = 7'b0010010;
        s3[2] = 7'b1001111;
        i = 0;
        while (d3_fs !== 1'b1 && i < 50) begin
            @(negedge clock);
            i++;
        end
        chk("d3_frame_timeout", {31'd0, d3_fs}, 32'd1);
        for (int t = 0; t < 24; t++) begin
            @(posedge clock);
            @(negedge clock);
            chk("d3_fs", {31'd0, d3_fs}, {31'd0, (t % 12) == 11});
            if (t % 4 == 1) begin
                a3 = 3'b1 << ((t / 4) % 3);
                chk("d3_an", {29'd0, d3_an}, {29'd0, ~a3});
                chk("d3_seg", {25'd0, d3_seg}, {25'd0, s3[(t / 4) % 3]});
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
